ifetch_stage: RTL and testbench
===============================

# ifetch_stage

Instruction fetch stage for the pipelined LC-3b datapath. It owns the PC, issues reads on the instruction memory port, and holds the fetched instruction register. It presents `opcode`, `ir4`, `ir5` and `ir11` to the decode stage's control ROM, plus the full IR and incremented PC. Downstream stalls and branch/jump/trap redirects from later stages are absorbed here without losing or duplicating instructions.

## Interface
- No parameters. Word width is fixed at 16 bits (`lc3b_word`); the opcode is `lc3b_opcode` (4 bits).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `imem_read`  out  1  instruction read request; held high until `imem_resp`.
- `imem_address`  out  16  read address; bit 0 always 0.
- `imem_resp`  in  1  one-cycle pulse; `imem_rdata` valid this cycle.
- `imem_rdata`  in  16  instruction word.
- `stall`  in  1  decode cannot accept the held instruction this cycle.
- `redirect`  in  1  load a new PC and flush all fetched-but-unconsumed instructions.
- `redirect_pc`  in  16  target PC; bit 0 is ignored and forced to 0.
- `if_valid`  out  1  `if_ir` and `if_pc` hold a live instruction.
- `if_ir`  out  16  instruction register.
- `if_pc`  out  16  address of the instruction plus 2.
- `opcode`  out  4  `if_ir[15:12]`, combinational from the register.
- `ir4`, `ir5`, `ir11`  out  1 each  `if_ir[4]`, `if_ir[5]`, `if_ir[11]`.

## Operation
- Registers:
  - `pc`: next fetch address.
  - Output register: `if_valid`, `if_ir`, `if_pc`.
  - One-entry skid: `skid_ir`, `skid_pc`.
  - State register.
- States:
  - FETCH: `imem_read`=1, `imem_address`=`pc`.
  - HOLD: `imem_read`=0; the skid holds a word.
  - DISCARD: `imem_read`=1 at the old address; the response will be dropped.
- Output register accepts a word when `!if_valid || !stall`. This is the "accept" condition below.
- FETCH with `imem_resp` and no redirect:
  - If accept: load `if_ir`←`imem_rdata`, `if_pc`←`pc+2`, `if_valid`←1; set `pc`←`pc+2`; stay in FETCH.
  - Otherwise: load the skid and set `pc`←`pc+2`; go to HOLD.
- FETCH without `imem_resp`, no redirect: if accept, clear `if_valid`; stay in FETCH.
- HOLD: when `!stall`, move the skid into the output register (`if_valid`=1) and go to FETCH. When `stall`, hold everything.
- Redirect has priority over everything else, including `stall`:
  - Clear `if_valid` and `if_ir` to 0x0000, and empty the skid.
  - Set `pc`←`{redirect_pc[15:1],0}`.
  - If in FETCH without `imem_resp`: go to DISCARD. The in-flight read cannot be retracted, so its address stays stable.
  - Otherwise (FETCH with response, HOLD, DISCARD with response): go to FETCH. Any arriving `imem_rdata` is dropped.
- DISCARD:
  - On `imem_resp`: drop the data and go to FETCH, which fetches the new `pc`.
  - A further redirect in DISCARD without a response only overwrites `pc`.
- `if_ir`=0x0000 whenever `if_valid`=0. This decodes as BR with nzp=000, a NOP to the control ROM.
- PC arithmetic is mod 2^16: 0xFFFE+2 = 0x0000.

## Timing
- Reset values:
  - Internal: `pc`=0x0000, state=FETCH, skid empty.
  - Outputs: `if_valid`=0, `if_ir`=0x0000, `if_pc`=0x0000, `opcode`=0, `ir4`/`ir5`/`ir11`=0.
  - `imem_read`=0 while `rst` is high.
- First cycle after reset deasserts: `imem_read`=1, `imem_address`=0x0000.
- Latency: `imem_resp` in cycle N gives `if_valid`/`if_ir` in cycle N+1.
  - With a zero-wait memory (response in the request cycle), throughput is one instruction per cycle.
- `imem_address` must not change while `imem_read`=1 and `imem_resp`=0.
- Reset mid-request: the state is abandoned immediately. The memory model must tolerate a dropped request.
- `stall` with `if_valid`=0 has no effect on acceptance.

## Test plan
- Reset, zero-wait memory returning 0x1042, 0x5263, 0x9FFF at 0x0000/0x0002/0x0004:
  - `if_ir` shows them on consecutive cycles with `if_pc` 0x0002/0x0004/0x0006.
  - Decode outputs: `opcode`=1 with `ir5`=0, then `opcode`=5 with `ir5`=1, then `opcode`=9.
- `stall` held for 3 cycles while a response arrives:
  - Word goes to the skid; `imem_read` drops.
  - On release, the next two instructions appear in order with no duplicate or loss.
- Redirect to 0x3001 with a 2-wait-state fetch outstanding at 0x0008:
  - `imem_address` stays 0x0008 until the response, which is dropped; `if_valid`=0 throughout.
  - Next request is to 0x3000.
- Redirect and `imem_resp` in the same cycle, with `stall`=1:
  - `if_valid` goes to 0 and the response is dropped.
  - Next address is the target.
- Redirect to 0xFFFE: fetches 0xFFFE then 0x0000; `if_pc` is 0x0000 then 0x0002.
- Assert `rst` while in HOLD:
  - All outputs return to their reset values asynchronously.
  - Fetch restarts at 0x0000.

Source files
------------

// File: rtl/ifetch_stage.sv
// Instruction fetch stage for the pipelined LC-3b: owns the PC, drives the
// instruction memory read port and holds the fetched IR for decode.
module ifetch_stage (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output logic [15:0] imem_address,
   input  logic        imem_resp,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        if_valid,
   output logic [15:0] if_ir,
   output logic [15:0] if_pc,
   output logic [3:0]  opcode,
   output logic        ir4,
   output logic        ir5,
   output logic        ir11
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [15:0] pc_r, pc_s;
   logic [15:0] disc_addr_r, disc_addr_s;
   logic [15:0] skid_ir_r, skid_ir_s;
   logic [15:0] skid_pc_r, skid_pc_s;
   logic        valid_r, valid_s;
   logic [15:0] ir_r, ir_s;
   logic [15:0] opc_r, opc_s;
   logic        accept_s;
   logic [15:0] pc_inc_s;

   function automatic logic [15:0] word_inc(input logic [15:0] a);
      return a + 16'd2;
   endfunction

   // Next-state, PC, skid and output-register logic.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      disc_addr_s = disc_addr_r;
      skid_ir_s   = skid_ir_r;
      skid_pc_s   = skid_pc_r;
      valid_s     = valid_r;
      ir_s        = ir_r;
      opc_s       = opc_r;
      accept_s    = !valid_r || !stall;
      pc_inc_s    = word_inc(pc_r);

      if (redirect) begin
         // A redirect flushes everything; an unretractable read is ridden out in DISCARD.
         valid_s   = 1'b0;
         ir_s      = 16'h0000;
         skid_ir_s = 16'h0000;
         skid_pc_s = 16'h0000;
         pc_s      = {redirect_pc[15:1], 1'b0};
         if ((state_r == FETCH) && !imem_resp) begin
            state_s     = DISCARD;
            disc_addr_s = pc_r;
         end else if ((state_r == DISCARD) && !imem_resp) begin
            state_s = DISCARD;
         end else begin
            state_s = FETCH;
         end
      end else begin
         case (state_r)
            FETCH: begin
               if (imem_resp) begin
                  pc_s = pc_inc_s;
                  if (accept_s) begin
                     valid_s = 1'b1;
                     ir_s    = imem_rdata;
                     opc_s   = pc_inc_s;
                  end else begin
                     skid_ir_s = imem_rdata;
                     skid_pc_s = pc_inc_s;
                     state_s   = HOLD;
                  end
               end else begin
                  if (accept_s) begin
                     valid_s = 1'b0;
                     ir_s    = 16'h0000;
                  end else begin
                     valid_s = valid_r;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  valid_s = 1'b1;
                  ir_s    = skid_ir_r;
                  opc_s   = skid_pc_r;
                  state_s = FETCH;
               end else begin
                  state_s = HOLD;
               end
            end
            DISCARD: begin
               if (imem_resp) begin
                  state_s = FETCH;
               end else begin
                  state_s = DISCARD;
               end
            end
            default: begin
               state_s = FETCH;
               valid_s = 1'b0;
               ir_s    = 16'h0000;
            end
         endcase
      end
   end

   // State, PC, skid and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= FETCH;
         pc_r        <= 16'h0000;
         disc_addr_r <= 16'h0000;
         skid_ir_r   <= 16'h0000;
         skid_pc_r   <= 16'h0000;
         valid_r     <= 1'b0;
         ir_r        <= 16'h0000;
         opc_r       <= 16'h0000;
      end else begin
         state_r     <= state_s;
         pc_r        <= pc_s;
         disc_addr_r <= disc_addr_s;
         skid_ir_r   <= skid_ir_s;
         skid_pc_r   <= skid_pc_s;
         valid_r     <= valid_s;
         ir_r        <= ir_s;
         opc_r       <= opc_s;
      end
   end

   // Memory port: DISCARD keeps the abandoned address stable until its response.
   always_comb begin
      imem_read = !rst && (state_r != HOLD);
      if (state_r == DISCARD) begin
         imem_address = disc_addr_r;
      end else begin
         imem_address = pc_r;
      end
   end

   assign if_valid = valid_r;
   assign if_ir    = ir_r;
   assign if_pc    = opc_r;
   assign opcode   = ir_r[15:12];
   assign ir4      = ir_r[4];
   assign ir5      = ir_r[5];
   assign ir11     = ir_r[11];

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios plus randomized
// stall/redirect/wait-state traffic checked against an instruction-stream scoreboard.
module tb_ifetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read;
   logic [15:0] imem_address;
   logic        imem_resp;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic [15:0] if_ir;
   logic [15:0] if_pc;
   logic [3:0]  opcode;
   logic        ir4, ir5, ir11;

   int          nvec = 0;
   int          nfail = 0;
   int          consumed = 0;
   logic [15:0] exp_pc;
   int          wait_lo, wait_hi;
   bit          busy;
   int          cnt;
   bit          prev_pend;
   logic [15:0] prev_addr;

   ifetch_stage dut (
      .clk(clk), .rst(rst),
      .imem_read(imem_read), .imem_address(imem_address),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc),
      .opcode(opcode), .ir4(ir4), .ir5(ir5), .ir11(ir11)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h1042;
         16'h0002: return 16'h5263;
         16'h0004: return 16'h9FFF;
         default:  return a ^ 16'h3C5A;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      nvec++;
      if (got !== want) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   // One clock: drive inputs at the falling edge, model memory, score consumption.
   task automatic cycle(input logic st, input logic rd, input logic [15:0] tgt);
      stall       = st;
      redirect    = rd;
      redirect_pc = tgt;
      if (imem_read) begin
         if (prev_pend) check("addr_stable", imem_address, prev_addr);
         check("addr_even", {15'd0, imem_address[0]}, 16'd0);
         if (!busy) begin
            busy = 1'b1;
            cnt  = int'($urandom_range(wait_hi, wait_lo));
         end
         if (cnt == 0) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(imem_address);
            busy       = 1'b0;
         end else begin
            imem_resp  = 1'b0;
            imem_rdata = 16'($urandom);
            cnt--;
         end
      end else begin
         imem_resp = 1'b0;
         busy      = 1'b0;
      end
      prev_pend = imem_read && !imem_resp;
      prev_addr = imem_address;
      if (if_valid && !st && !rd) begin
         check("sb_ir", if_ir, mem_word(exp_pc));
         check("sb_pc", if_pc, exp_pc + 16'd2);
         exp_pc = exp_pc + 16'd2;
         consumed++;
      end
      if (rd) exp_pc = {tgt[15:1], 1'b0};
      @(posedge clk);
      @(negedge clk);
      if (!if_valid) check("nop_ir", if_ir, 16'h0000);
      check("decode", {9'd0, opcode, ir11, ir5, ir4},
            {9'd0, if_ir[15:12], if_ir[11], if_ir[5], if_ir[4]});
   endtask

   task automatic model_reset();
      busy = 1'b0; cnt = 0; prev_pend = 1'b0; exp_pc = 16'h0000;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
      imem_resp = 1'b0; imem_rdata = 16'h0000;
      wait_lo = 0; wait_hi = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check("rst_valid", {15'd0, if_valid}, 16'd0);
      check("rst_ir", if_ir, 16'h0000);
      check("rst_pc", if_pc, 16'h0000);
      check("rst_opc", {12'd0, opcode}, 16'd0);
      check("rst_read", {15'd0, imem_read}, 16'd0);
      rst = 1'b0;
      #1;
      check("first_read", {15'd0, imem_read}, 16'd1);
      check("first_addr", imem_address, 16'h0000);

      // Zero-wait stream
      cycle(1'b0, 1'b0, 16'h0);
      check("s1_ir", if_ir, 16'h1042); check("s1_pc", if_pc, 16'h0002);
      check("s1_opc", {12'd0, opcode}, 16'd1); check("s1_ir5", {15'd0, ir5}, 16'd0);
      cycle(1'b0, 1'b0, 16'h0);
      check("s2_ir", if_ir, 16'h5263); check("s2_pc", if_pc, 16'h0004);
      check("s2_opc", {12'd0, opcode}, 16'd5); check("s2_ir5", {15'd0, ir5}, 16'd1);
      cycle(1'b0, 1'b0, 16'h0);
      check("s3_ir", if_ir, 16'h9FFF); check("s3_pc", if_pc, 16'h0006);
      check("s3_opc", {12'd0, opcode}, 16'd9);

      // Stall for three cycles while a response arrives
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 16'h0);
         check("stall_read", {15'd0, imem_read}, 16'd0);
         check("stall_ir", if_ir, 16'h9FFF);
      end
      cycle(1'b0, 1'b0, 16'h0);
      check("skid_ir", if_ir, mem_word(16'h0006)); check("skid_pc", if_pc, 16'h0008);

      // Redirect during a 2-wait fetch at 0x0008
      wait_lo = 2; wait_hi = 2;
      cycle(1'b0, 1'b0, 16'h0);
      check("disc_v0", {15'd0, if_valid}, 16'd0);
      cycle(1'b0, 1'b1, 16'h3001);
      check("disc_addr", imem_address, 16'h0008);
      check("disc_v1", {15'd0, if_valid}, 16'd0);
      cycle(1'b0, 1'b0, 16'h0);
      check("disc_v2", {15'd0, if_valid}, 16'd0);
      check("disc_next", imem_address, 16'h3000);

      // Redirect coinciding with a response while stalled
      wait_lo = 0; wait_hi = 0;
      cycle(1'b0, 1'b0, 16'h0);
      check("t4_ir", if_ir, mem_word(16'h3000));
      cycle(1'b1, 1'b1, 16'h4000);
      check("t4_valid", {15'd0, if_valid}, 16'd0);
      check("t4_ir0", if_ir, 16'h0000);
      check("t4_addr", imem_address, 16'h4000);

      // Wrap from 0xFFFE to 0x0000
      cycle(1'b0, 1'b1, 16'hFFFF);
      check("wrap_addr", imem_address, 16'hFFFE);
      cycle(1'b0, 1'b0, 16'h0);
      check("wrap_ir0", if_ir, mem_word(16'hFFFE)); check("wrap_pc0", if_pc, 16'h0000);
      cycle(1'b0, 1'b0, 16'h0);
      check("wrap_ir1", if_ir, 16'h1042); check("wrap_pc1", if_pc, 16'h0002);

      // Reset asserted in HOLD
      cycle(1'b1, 1'b0, 16'h0);
      check("hold_read", {15'd0, imem_read}, 16'd0);
      #2 rst = 1'b1; stall = 1'b0;
      #1;
      check("arst_valid", {15'd0, if_valid}, 16'd0);
      check("arst_ir", if_ir, 16'h0000);
      check("arst_pc", if_pc, 16'h0000);
      check("arst_opc", {12'd0, opcode, ir11, ir5, ir4}, 16'd0);
      check("arst_read", {15'd0, imem_read}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      check("rst2_read", {15'd0, imem_read}, 16'd1);
      check("rst2_addr", imem_address, 16'h0000);
      cycle(1'b0, 1'b0, 16'h0);
      check("rst2_ir", if_ir, 16'h1042);

      // Randomized traffic
      wait_lo = 0; wait_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         logic        st, rd;
         logic [15:0] tgt;
         st  = ($urandom_range(99, 0) < 30);
         rd  = ($urandom_range(99, 0) < 5);
         tgt = ($urandom_range(3, 0) == 0) ? 16'hFFFA + 16'($urandom_range(5, 0))
                                          : 16'($urandom);
         cycle(st, rd, tgt);
      end
      check("liveness", {15'd0, consumed >= 200}, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
